// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared adder package: controller states and default width
package add_pkg;

   // Default operand width shared by the parallel adders and the serial controller
   localparam int ADD_WIDTH = 8;

   // Serial controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } add_state_t;

endpackage

// File: rtl/fa_bit_cell.sv
// rtl/fa_bit_cell.sv - one-bit full-adder cell with propagate output
module fa_bit_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic p,
   output logic co
);

   // Propagate is shared by the sum and the carry; carry-out is majority(a, b, ci)
   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first, one bit per clock
module serial_add_ctrl
   import add_pkg::*;
#(
   parameter  int WIDTH = ADD_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             prop_all,
   output logic             busy
);

   add_state_t       state;
   logic [WIDTH-1:0] sa;        // operand A; sum bits shift in at the top as A drains
   logic [WIDTH-1:0] sb;        // operand B
   logic             carry;
   logic             prop_acc;
   logic [CNT_W-1:0] count;
   logic             bit_s;
   logic             bit_p;
   logic             bit_c;
   logic             last_bit;

   fa_bit_cell u_cell (
      .a  (sa[0]),
      .b  (sb[0]),
      .ci (carry),
      .s  (bit_s),
      .p  (bit_p),
      .co (bit_c)
   );

   assign last_bit  = (count == CNT_W'(WIDTH - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Sequencer: load operands, step the bit cell WIDTH times, then hold the result for the consumer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         carry    <= 1'b0;
         prop_acc <= 1'b0;
         count    <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
         prop_all <= 1'b0;
      end else if (flush) begin
         // Abort wins over any handshake; the last published result stays visible
         state <= IDLE;
         count <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sa       <= a;
                  sb       <= b;
                  carry    <= cin;
                  count    <= '0;
                  prop_acc <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               sa       <= {bit_s, sa[WIDTH-1:1]};
               sb       <= {1'b0, sb[WIDTH-1:1]};
               carry    <= bit_c;
               prop_acc <= prop_acc & bit_p;
               if (last_bit) begin
                  // carry still holds the carry into the MSB at this point
                  sum      <= {bit_s, sa[WIDTH-1:1]};
                  cout     <= bit_c;
                  ovf      <= carry ^ bit_c;
                  prop_all <= prop_acc & bit_p;
                  state    <= DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for the bit-serial adder controller
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         prop_all;
   logic         busy;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         p;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .prop_all  (prop_all),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      exp_t         e;
      logic [W:0]   full;
      logic [W-1:0] low;
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, ci};
      e.s  = full[W-1:0];
      e.c  = full[W];
      e.o  = low[W-1] ^ full[W];
      e.p  = &(x ^ y);
      return e;
   endfunction

   // Called at a negedge; leaves the bench at the negedge after the accepting edge
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL start_op_ready: in_ready=%b required 1", in_ready);
      end
      a        = x;
      b        = y;
      cin      = ci;
      in_valid = 1'b1;
      sbq.push_back(model(x, y, ci));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      #3;
      n_cmp++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL reset_flags: out_valid/busy/in_ready=%b required 001", {out_valid, busy, in_ready});
      end
      n_cmp++;
      if ({sum, cout, ovf, prop_all} !== {{W{1'b0}}, 3'b000}) begin
         n_err++;
         $display("FAIL reset_result: sum=%h cout=%b ovf=%b prop=%b required all 0", sum, cout, ovf, prop_all);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_vectors;
      logic [W-1:0] ta [6] = '{8'h5A, 8'hFF, 8'hAA, 8'h00, 8'h7F, 8'h80};
      logic [W-1:0] tb [6] = '{8'h3C, 8'h01, 8'h55, 8'h00, 8'h01, 8'h80};
      logic         tc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
      exp_t         e;
      int           lat;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         start_op(ta[i], tb[i], tc[i]);
         wait_valid(lat);
         n_cmp++;
         if (lat !== W) begin
            n_err++;
            $display("FAIL vec%0d_latency: got %0d cycles required %0d", i, lat, W);
         end
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if ({sum, cout, ovf, prop_all} !== e) begin
               n_err++;
               $display("FAIL vec%0d_result: got sum=%h cout=%b ovf=%b prop=%b required sum=%h cout=%b ovf=%b prop=%b",
                        i, sum, cout, ovf, prop_all, e.s, e.c, e.o, e.p);
            end
         end
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL vec%0d_release: busy=%b in_ready=%b required 0/1", i, busy, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      int   lat;
      out_ready = 1'b0;
      start_op(8'h5A, 8'h3C, 1'b0);
      wait_valid(lat);
      n_cmp++;
      if (lat !== W) begin
         n_err++;
         $display("FAIL bp_latency: got %0d cycles required %0d", lat, W);
      end
      e = sbq.pop_front();
      n_cmp++;
      if ({sum, cout, ovf, prop_all} !== e) begin
         n_err++;
         $display("FAIL bp_result: got sum=%h required %h", sum, e.s);
      end
      a        = 8'h11;
      b        = 8'h22;
      cin      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || sum !== e.s || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold%0d: out_valid=%b sum=%h in_ready=%b required 1/%h/0", i, out_valid, sum, in_ready, e.s);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      sbq.push_back(model(8'h11, 8'h22, 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL bp_accept: busy=%b required 1", busy);
      end
      wait_valid(lat);
      n_cmp++;
      if (lat !== W) begin
         n_err++;
         $display("FAIL bp2_latency: got %0d cycles required %0d", lat, W);
      end
      e = sbq.pop_front();
      n_cmp++;
      if ({sum, cout, ovf, prop_all} !== e) begin
         n_err++;
         $display("FAIL bp2_result: got sum=%h required %h", sum, e.s);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun;
      exp_t e;
      int   lat;
      out_ready = 1'b1;
      start_op(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (sum !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midrun_reset: sum=%h out_valid=%b busy=%b in_ready=%b required 00/0/0/1",
                  sum, out_valid, busy, in_ready);
      end
      sbq.delete();
      @(negedge clk);
      rst = 1'b0;
      start_op(8'h01, 8'h01, 1'b0);
      wait_valid(lat);
      e = sbq.pop_front();
      n_cmp++;
      if (lat !== W || {sum, cout, ovf, prop_all} !== e) begin
         n_err++;
         $display("FAIL post_reset_add: lat=%0d sum=%h required lat=%0d sum=%h", lat, sum, W, e.s);
      end
      @(negedge clk);
   endtask

   task automatic test_flush;
      bit seen = 1'b0;
      out_ready = 1'b1;
      start_op(8'h5A, 8'h3C, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h02) begin
         n_err++;
         $display("FAIL flush_run: busy=%b out_valid=%b sum=%h required 0/0/02", busy, out_valid, sum);
      end
      sbq.delete();
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL flush_no_result: out_valid seen=%b required 0", seen);
      end
      a        = 8'hFF;
      b        = 8'hFF;
      flush    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_idle_accept: busy=%b in_ready=%b required 0/1", busy, in_ready);
      end
   endtask

   task automatic test_back_to_back;
      int   acc   = 0;
      int   got   = 0;
      int   cyc   = 0;
      int   last  = -1;
      bit   renew = 1'b0;
      exp_t e;
      out_ready = 1'b1;
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      in_valid  = 1'b1;
      while (got < 6 && cyc < 200) begin
         if (out_valid) begin
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               n_cmp++;
               if ({sum, cout, ovf, prop_all} !== e) begin
                  n_err++;
                  $display("FAIL b2b%0d_result: got sum=%h cout=%b ovf=%b prop=%b required sum=%h cout=%b ovf=%b prop=%b",
                           got, sum, cout, ovf, prop_all, e.s, e.c, e.o, e.p);
               end
            end
            got++;
         end
         if (in_ready && in_valid) begin
            sbq.push_back(model(a, b, cin));
            if (last >= 0) begin
               n_cmp++;
               if (cyc - last !== W + 2) begin
                  n_err++;
                  $display("FAIL b2b_interval: got %0d cycles required %0d", cyc - last, W + 2);
               end
            end
            last  = cyc;
            acc++;
            renew = 1'b1;
         end else if (renew) begin
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            renew    = 1'b0;
            in_valid = (acc < 6);
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (got !== 6) begin
         n_err++;
         $display("FAIL b2b_count: got %0d results required 6", got);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_midrun();
      test_flush();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
